// File: rtl/alu_seq.sv
// Multi-cycle sequencer driving an 8-operation combinational ALU from a small register file.
// Optional zero-flag cross-check enabled by defining ALU_SEQ_ZCHECK_EN.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREG  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic [3+3*$clog2(NREG)-1:0]   instr,
  input  logic                          wr_en,
  input  logic [$clog2(NREG)-1:0]       wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [WIDTH-1:0]              alu_A,
  output logic [WIDTH-1:0]              alu_B,
  output logic [2:0]                    alu_Op,
  input  logic [WIDTH-1:0]              alu_S,
  input  logic                          alu_zero,
  output logic [WIDTH-1:0]              result,
  output logic                          zero_flag,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned IW = 3 + 3 * AW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WB    = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             accept_c;
  logic [WIDTH-1:0] rf [NREG];
  logic [AW-1:0]    rd_q;

  logic [2:0]    op_c;
  logic [AW-1:0] rd_c;
  logic [AW-1:0] ra_c;
  logic [AW-1:0] rb_c;

  assign op_c = instr[IW-1 -: 3];
  assign rd_c = instr[3*AW-1 -: AW];
  assign ra_c = instr[2*AW-1 -: AW];
  assign rb_c = instr[AW-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; acceptance only possible in IDLE
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          accept_c  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, writeback, register file; ALU writeback overrides an external write
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_ready <= 1'b1;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_Op      <= 3'b000;
      rd_q        <= '0;
      result      <= '0;
      zero_flag   <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else begin
      instr_ready <= (state_nxt == IDLE);
      done        <= (state == ISSUE);
      if (accept_c) begin
        alu_Op <= op_c;
        alu_A  <= rf[ra_c];
        alu_B  <= rf[rb_c];
        rd_q   <= rd_c;
      end
      if (wr_en) rf[wr_addr] <= wr_data;
      if (state == ISSUE) begin
        rf[rd_q]  <= alu_S;
        result    <= alu_S;
        zero_flag <= alu_zero;
      end
    end
  end

`ifdef ALU_SEQ_ZCHECK_EN
  // Sticky flag: ALU-reported zero disagrees with the result it produced
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if ((state == ISSUE) && ((alu_S == '0) != alu_zero)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle sequencer that drives the team's 8-operation combinational ALU from the initiator side.
- Accepts register-to-register instructions over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU operand and opcode inputs from registers, then captures the ALU result and zero flag back into the register file.
- Sits between the instruction source (bench or future fetch unit) and the ALU instance.

Parameters:
- WIDTH, 8, datapath width; must match the ALU operand width.
- NREG, 4, register file depth; power of 2, ≥2. AW = $clog2(NREG).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept an instruction
- instr  in  3+3*AW  packed {op[2:0], rd, ra, rb}
- wr_en  in  1  external register write strobe
- wr_addr  in  AW  external write address
- wr_data  in  WIDTH  external write data
- alu_A  out  WIDTH  ALU operand A
- alu_B  out  WIDTH  ALU operand B
- alu_Op  out  3  ALU operation select
- alu_S  in  WIDTH  ALU result
- alu_zero  in  1  ALU zero flag
- result  out  WIDTH  last captured ALU result
- zero_flag  out  1  last captured zero flag
- done  out  1  one-cycle pulse: instruction retired
- err  out  1  sticky zero-flag mismatch (see Optional Feature)

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; alu_A, alu_B, result = 0; alu_Op = 3'b000; zero_flag, done, err = 0; all register file entries = 0.
- instr_ready is a decode of state: 1 only in IDLE. It does not depend combinationally on instr_valid.
- FSM has three states:
  - IDLE: on instr_valid & instr_ready, register alu_Op<=op, alu_A<=rf[ra], alu_B<=rf[rb], and latch rd. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: the ALU settles combinationally. At the clock edge: rf[rd]<=alu_S, result<=alu_S, zero_flag<=alu_zero. Go to WB.
  - WB: done=1 for exactly this cycle. Go to IDLE unconditionally.
- Latency: accept at edge N; done high during cycle N+2. Throughput is one instruction per 3 cycles.
- alu_A, alu_B and alu_Op hold their last values outside ISSUE; they are not cleared.
- instr_valid while busy: ignored, with no side effects. The source must hold the instruction until ready; it is accepted on the first IDLE cycle.
- ra == rb is legal; both operands read the same register.
- rd may equal ra or rb. Operands are latched at acceptance, so the writeback does not disturb the current operation.
- wr_en is honoured in any state: rf[wr_addr]<=wr_data.
  - Collision with the ISSUE writeback to the same address: the ALU writeback wins.
  - Collision with acceptance: the operand read in IDLE sees the old value (no bypass).
- Arithmetic is performed by the ALU, modulo 2^WIDTH. The controller performs no width extension.
- Reset in ISSUE or WB: the writeback is abandoned (rf[rd] not written, result and zero_flag not updated), done does not pulse, and reset values apply on the next cycle.

Optional Feature:
- Macro: ALU_SEQ_ZCHECK_EN.
- Defined: in ISSUE, the controller computes its own zero as (alu_S == 0). If it differs from alu_zero, err<=1. err is sticky until reset. zero_flag still takes alu_zero.
- Undefined: no check logic; err is tied to 0.

Test Plan:
- Write r0=8'h05 and r1=8'h03; issue op=010 rd=2 ra=0 rb=1. Expect: done 2 cycles after accept, result=8'h08, zero_flag=0, rf[2]=8'h08 (confirmed by a following op=000 ra=2 giving result 8'h08).
- Issue op=011 rd=3 ra=0 rb=0 with r0=8'h05. Expect: result=8'h00, zero_flag=1. Then op=111 rb=1 with r1=8'h03. Expect: result=8'hFD, zero_flag=0.
- Hold instr_valid high for 8 cycles with the same instruction. Expect: instr_ready high only on cycles 0, 3 and 6; exactly 3 done pulses.
- In ISSUE, assert wr_en with wr_addr=rd and wr_data=8'hAA. Expect: rd holds the ALU result, not 8'hAA. wr_en to another address in the same cycle is written.
- Assert reset during ISSUE of op=010 targeting r2 (r2 previously 8'h11). Expect: no done pulse; all outputs and all registers at reset values (r2 = 0) on the next cycle.
- With ALU_SEQ_ZCHECK_EN defined and a bench stub forcing alu_zero=1 while alu_S=8'h01: expect err=1 from WB onward, staying set through later good operations until reset.
